// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - request/grant bundle between requesters and the 8:1 mux arbiter
interface mux8_rr_arbiter_if;
   logic       en;
   logic [7:0] req;
   logic       s2;
   logic       s1;
   logic       s0;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   modport master (
      output en, req,
      input  s2, s1, s0, gnt, busy, timeout
   );

   modport slave (
      input  en, req,
      output s2, s1, s0, gnt, busy, timeout
   );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin 8-way arbiter driving a registered 8:1 mux select
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mux8_rr_arbiter_if.slave  arb
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] hold_q, hold_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;

   logic [2:0] win;
   logic [2:0] idx;
   logic       found;

   // First requester at or after the pointer, wrapping modulo 8.
   always_comb begin
      win   = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr_q + 3'(k);
         if (!found && arb.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      sel_d     = sel_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_d  = 8'h00;
            busy_d = 1'b0;
            if (arb.en && found) begin
               state_d = GRANT;
               sel_d   = win;
               gnt_d   = 8'h01 << win;
               busy_d  = 1'b1;
               hold_d  = 4'd1;
            end
         end
         GRANT: begin
            if (!arb.req[sel_q] || hold_q == MAX_HOLD_C) begin
               // Pointer moves past the winner so every waiting requester gets a turn.
               state_d   = IDLE;
               gnt_d     = 8'h00;
               busy_d    = 1'b0;
               hold_d    = 4'd0;
               ptr_d     = sel_q + 3'd1;
               timeout_d = arb.req[sel_q];
            end else if (hold_q != 4'hF) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         hold_q    <= 4'd0;
         sel_q     <= 3'd0;
         gnt_q     <= 8'h00;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         sel_q     <= sel_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb.s2      = sel_q[2];
   assign arb.s1      = sel_q[1];
   assign arb.s0      = sel_q[0];
   assign arb.gnt     = gnt_q;
   assign arb.busy    = busy_q;
   assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic chk_on = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   mux8_rr_arbiter_if arb_if ();

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (arb_if)
   );

   always #5 clk = ~clk;

   // Reference: who holds the mux, for how long, and where the next search starts.
   bit       m_busy = 1'b0;
   bit       m_to = 1'b0;
   int       m_win = 0;
   int       m_held = 0;
   int       m_ptr = 0;
   logic [2:0] m_sel = 3'd0;

   always @(posedge clk or negedge rst_n) begin : model
      int w;
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_to   <= 1'b0;
         m_win  <= 0;
         m_held <= 0;
         m_ptr  <= 0;
         m_sel  <= 3'd0;
      end else begin
         m_to <= 1'b0;
         if (!m_busy) begin
            if (arb_if.en && arb_if.req != 8'h00) begin
               w = -1;
               for (int k = 0; k < 8; k++)
                  if (w < 0 && arb_if.req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
               m_busy <= 1'b1;
               m_win  <= w;
               m_sel  <= 3'(w);
               m_held <= 1;
            end
         end else if (!arb_if.req[m_win]) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_win + 1) % 8;
         end else if (m_held >= MAX_HOLD) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_win + 1) % 8;
            m_to   <= 1'b1;
         end else begin
            m_held <= m_held + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] dut_sel();
      return {arb_if.s2, arb_if.s1, arb_if.s0};
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_gnt", 32'(arb_if.gnt), m_busy ? 32'(1 << m_win) : 32'd0);
         check("model_sel", 32'(dut_sel()), 32'(m_sel));
         check("model_busy", 32'(arb_if.busy), 32'(m_busy));
         check("model_timeout", 32'(arb_if.timeout), 32'(m_to));
      end
   end

   task automatic nedge();
      @(negedge clk);
   endtask

   initial begin
      int idle;
      int len;
      logic [7:0] r;
      arb_if.en  = 1'b0;
      arb_if.req = 8'h00;
      nedge(); nedge();
      check("reset_gnt", 32'(arb_if.gnt), 32'h0);
      check("reset_sel", 32'(dut_sel()), 32'h0);
      check("reset_busy", 32'(arb_if.busy), 32'h0);
      check("reset_timeout", 32'(arb_if.timeout), 32'h0);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // Single requester, release moves pointer to 1.
      arb_if.en = 1'b1; arb_if.req = 8'h01;
      nedge();
      check("r0_gnt", 32'(arb_if.gnt), 32'h01);
      check("r0_sel", 32'(dut_sel()), 32'h0);
      check("r0_busy", 32'(arb_if.busy), 32'h1);
      arb_if.req = 8'h00;
      nedge();
      check("r0_drop_gnt", 32'(arb_if.gnt), 32'h00);
      check("r0_drop_busy", 32'(arb_if.busy), 32'h0);
      check("r0_drop_to", 32'(arb_if.timeout), 32'h0);
      arb_if.req = 8'h03;
      nedge();
      check("ptr1_gnt", 32'(arb_if.gnt), 32'h02);
      arb_if.req = 8'h00;
      nedge();

      // Grant 5, then 6 over 0, then wrap to 0.
      arb_if.req = 8'h20;
      nedge();
      check("g5_sel", 32'(dut_sel()), 32'h5);
      arb_if.req = 8'h00;
      nedge();
      arb_if.req = 8'h41;
      nedge();
      check("g6_gnt", 32'(arb_if.gnt), 32'h40);
      check("g6_sel", 32'(dut_sel()), 32'h6);
      arb_if.req = 8'h01;
      nedge();
      check("g6_rel_gnt", 32'(arb_if.gnt), 32'h00);
      check("g6_rel_sel_hold", 32'(dut_sel()), 32'h6);
      nedge();
      check("wrap_gnt", 32'(arb_if.gnt), 32'h01);
      check("wrap_sel", 32'(dut_sel()), 32'h0);
      arb_if.req = 8'h00;
      nedge();

      // Grant 3 ignores other requesters and EN going low.
      arb_if.req = 8'h08;
      nedge();
      check("g3_gnt", 32'(arb_if.gnt), 32'h08);
      arb_if.en = 1'b0; arb_if.req = 8'h28;
      nedge();
      check("g3_hold_a", 32'(arb_if.gnt), 32'h08);
      arb_if.req = 8'h08;
      nedge();
      check("g3_hold_b", 32'(arb_if.gnt), 32'h08);
      arb_if.req = 8'h28;
      nedge();
      check("g3_hold_c", 32'(arb_if.gnt), 32'h08);
      arb_if.req = 8'h20;
      nedge();
      check("g3_drop", 32'(arb_if.gnt), 32'h00);
      nedge();
      check("en0_no_grant", 32'(arb_if.gnt), 32'h00);
      check("en0_busy", 32'(arb_if.busy), 32'h0);

      // Asynchronous reset at hold count 4.
      arb_if.en = 1'b1; arb_if.req = 8'h10;
      nedge();
      check("g4_gnt", 32'(arb_if.gnt), 32'h10);
      nedge(); nedge(); nedge();
      #2 rst_n = 1'b0;
      #1;
      check("async_gnt", 32'(arb_if.gnt), 32'h00);
      check("async_sel", 32'(dut_sel()), 32'h0);
      check("async_to", 32'(arb_if.timeout), 32'h0);
      check("async_busy", 32'(arb_if.busy), 32'h0);
      arb_if.req = 8'h80;
      nedge();
      #2 rst_n = 1'b1;
      nedge();
      check("post_rst_gnt", 32'(arb_if.gnt), 32'h80);
      check("post_rst_sel", 32'(dut_sel()), 32'h7);

      // All requesting: 0..7,0 each for MAX_HOLD cycles with timeout and one idle cycle.
      nedge();
      #2 rst_n = 1'b0;
      arb_if.req = 8'hFF;
      nedge();
      #2 rst_n = 1'b1;
      nedge();
      for (int g = 0; g < 9; g++) begin
         idle = 0;
         while (arb_if.gnt == 8'h00 && idle < 5) begin
            idle++;
            nedge();
         end
         if (g > 0) check("ff_idle", 32'(idle), 32'd1);
         check("ff_order", 32'(arb_if.gnt), 32'(8'h01 << (g % 8)));
         len = 0;
         while (arb_if.gnt == 8'(8'h01 << (g % 8)) && len < 20) begin
            len++;
            nedge();
         end
         check("ff_len", 32'(len), 32'(MAX_HOLD));
         check("ff_timeout", 32'(arb_if.timeout), 32'h1);
      end

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         nedge();
         r = arb_if.req;
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
         arb_if.req = r;
         arb_if.en  = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            nedge();
            #2 rst_n = 1'b1;
         end
      end
      nedge();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001: Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold a grant (legal 1..15).
REQ-002: CLK  input  1  single clock; all state updates on rising edge.
REQ-003: RST_N  input  1  asynchronous, active-low reset.
REQ-004: EN  input  1  arbitration enable; gates new grants only.
REQ-005: REQ  input  8  request vector; REQ[i] high = requester i wants the 8:1 mux path (i=0 maps to mux input A ... i=7 to H).
REQ-006: S2, S1, S0  output  1 each  registered mux select; {S2,S1,S0} = index of granted requester.
REQ-007: GNT  output  8  registered one-hot grant; all-zero when no grant.
REQ-008: BUSY  output  1  high while in GRANT state.
REQ-009: TIMEOUT  output  1  one-cycle pulse on forced release.

Function
REQ-010: FSM states SHALL be IDLE and GRANT only; all outputs SHALL be registered.
REQ-011: Internal 3-bit priority pointer PTR SHALL select the highest-priority index; search order PTR, PTR+1, ... PTR+7, modulo 8.
REQ-012: In IDLE with EN=1 and REQ!=0 at edge N, after edge N: state=GRANT, GNT=one-hot of winner, {S2,S1,S0}=winner index, BUSY=1 (latency one edge).
REQ-013: In IDLE with EN=0 or REQ=0, state SHALL stay IDLE, GNT=0, BUSY=0, select SHALL hold its last value.
REQ-014: Hold counter (4-bit) SHALL load 1 on entry to GRANT and increment each further GRANT cycle; it SHALL saturate, never wrap.
REQ-015: In GRANT, if REQ[winner]=0 at an edge: next state IDLE, GNT=0, BUSY=0, PTR=winner+1 mod 8, TIMEOUT=0.
REQ-016: In GRANT, if REQ[winner]=1 and hold counter == MAX_HOLD at an edge: next state IDLE, GNT=0, BUSY=0, PTR=winner+1 mod 8, TIMEOUT=1 for exactly that one following cycle.
REQ-017: GNT SHALL therefore be high for at most MAX_HOLD consecutive cycles per grant.
REQ-018: Every GRANT->IDLE transition SHALL produce at least one cycle of GNT=0 before the next grant (turnaround).
REQ-019: Changes on REQ bits other than REQ[winner] during GRANT SHALL have no effect on the current grant.
REQ-020: EN deasserting during GRANT SHALL NOT terminate the current grant.
REQ-021: Pointer wrap: winner 7 SHALL set PTR=0.
REQ-022: Simultaneous requests SHALL resolve strictly by REQ-011; no requester may be granted twice while another continuously requesting requester is skipped.
REQ-023: {S2,S1,S0} SHALL only change on the edge that issues a new grant.

Reset
REQ-024: RST_N low SHALL immediately (asynchronously) force state=IDLE, GNT=0, {S2,S1,S0}=000, BUSY=0, TIMEOUT=0, PTR=0, hold counter=0.
REQ-025: Reset asserted mid-grant SHALL drop GNT without producing a TIMEOUT pulse.
REQ-026: After RST_N rises, the first arbitration SHALL occur on the first rising edge with EN=1 and REQ!=0.

Verification
REQ-027: Reset, EN=1, REQ=8'h01 -> one edge later GNT=8'h01, select=000, BUSY=1; drop REQ -> next edge GNT=0, PTR=1.
REQ-028: EN=1, REQ=8'hFF held constant, MAX_HOLD=8 -> grants 0,1,2,...,7,0 in order, each GNT high exactly 8 cycles, TIMEOUT pulse after each, one idle cycle between grants.
REQ-029: PTR=6 (after granting 5), REQ=8'h41 -> grant index 6, select=110; then REQ=8'h01 -> grant index 0 (wrap check after index 7 pointer).
REQ-030: In GRANT to index 3, toggle REQ[5] and EN=0 -> GNT stays 8'h08 until REQ[3] drops; with EN=0 no new grant follows.
REQ-031: Assert RST_N low mid-grant at hold count 4 -> GNT=0, select=000, TIMEOUT=0 immediately without clock edge; release reset with REQ=8'h80 -> grant index 7 one edge later.
